// File: rtl/sram_controller_pkg.sv
// Shared widths and FSM encoding for the off-chip 16-bit SRAM word controller.
package sram_controller_pkg;

  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned SRAM_DQ_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StLo   = ST_LO,
    StHi   = ST_HI,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/sram_addr_gen.sv
// Byte address to SRAM word offset, and low/high halfword SRAM address select.
module sram_addr_gen
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE = 1024,
  parameter int unsigned SRAM_AW   = 18
) (
  input  logic [WORD_WIDTH-1:0] i_address,
  input  logic [SRAM_AW-2:0]    i_waddr_word,
  input  logic                  i_hi,
  output logic [SRAM_AW-2:0]    o_waddr_word,
  output logic [SRAM_AW-1:0]    o_sram_addr
);

  logic [WORD_WIDTH-1:0] w_waddr;
  logic                  w_unused;

  // Subtraction wraps mod 2^32; bits above the SRAM range are dropped silently.
  assign w_waddr      = {i_address[WORD_WIDTH-1:2], 2'b00} - WORD_WIDTH'(ADDR_BASE);
  assign o_waddr_word = w_waddr[SRAM_AW:2];
  assign o_sram_addr  = {i_waddr_word, i_hi};
  assign w_unused     = ^{w_waddr[WORD_WIDTH-1:SRAM_AW+1], w_waddr[1:0], i_address[1:0]};

endmodule

// File: rtl/sram_controller.sv
// MEM-stage initiator: one 32-bit word request becomes two 16-bit SRAM accesses, low first.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned ADDR_BASE     = 1024,
  parameter int unsigned SRAM_AW       = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WORD_WIDTH-1:0]    address,
  input  logic [WORD_WIDTH-1:0]    write_data,
  output logic [WORD_WIDTH-1:0]    read_data,
  output logic                     ready,
  output logic [SRAM_AW-1:0]       sram_addr,
  output logic [SRAM_DQ_WIDTH-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  input  logic [SRAM_DQ_WIDTH-1:0] sram_dq_in,
  output logic                     sram_we_n
);

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  state_e                   r_state, w_state_next;
  logic [3:0]               r_cnt, w_cnt_next;
  logic                     r_is_wr;
  logic [SRAM_AW-2:0]       r_waddr_word;
  logic [WORD_WIDTH-1:0]    r_wdata;
  logic [SRAM_DQ_WIDTH-1:0] r_rd_lo;
  logic [WORD_WIDTH-1:0]    r_read_data;
  logic [SRAM_AW-1:0]       r_sram_addr;
  logic [SRAM_DQ_WIDTH-1:0] r_dq_out;
  logic                     r_dq_oe;
  logic                     r_we_n;

  logic                     w_req, w_last, w_accept, w_op_wr, w_next_hi;
  logic [SRAM_AW-2:0]       w_waddr_new, w_waddr_sel;
  logic [WORD_WIDTH-1:0]    w_wdata_sel;
  logic [SRAM_AW-1:0]       w_sram_addr_next;

  assign w_req    = wr_en | rd_en;
  assign w_last   = (r_cnt == LastCnt);
  assign w_accept = (r_state == StIdle) && w_req;

  // Registered pad outputs for the first LO cycle must come from the live request.
  assign w_op_wr     = w_accept ? wr_en       : r_is_wr;
  assign w_waddr_sel = w_accept ? w_waddr_new : r_waddr_word;
  assign w_wdata_sel = w_accept ? write_data  : r_wdata;
  assign w_next_hi   = (w_state_next == StHi);

  sram_addr_gen #(
    .ADDR_BASE (ADDR_BASE),
    .SRAM_AW   (SRAM_AW)
  ) u_addr_gen (
    .i_address    (address),
    .i_waddr_word (w_waddr_sel),
    .i_hi         (w_next_hi),
    .o_waddr_word (w_waddr_new),
    .o_sram_addr  (w_sram_addr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    ready        = 1'b0;
    unique case (r_state)
      StIdle: begin
        ready = ~w_req;
        if (w_req) begin
          w_state_next = StLo;
          w_cnt_next   = 4'd0;
        end
      end
      StLo: begin
        w_cnt_next = w_last ? 4'd0 : r_cnt + 4'd1;
        if (w_last) w_state_next = StHi;
      end
      StHi: begin
        w_cnt_next = w_last ? 4'd0 : r_cnt + 4'd1;
        if (w_last) w_state_next = StDone;
      end
      StDone: begin
        ready        = 1'b1;
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr      <= 1'b0;
      r_waddr_word <= '0;
      r_wdata      <= '0;
    end else if (w_accept) begin
      r_is_wr      <= wr_en;
      r_waddr_word <= w_waddr_new;
      r_wdata      <= write_data;
    end
  end

  // we_n rises on the last cycle of each access so address and data are held past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else if (w_state_next == StLo || w_state_next == StHi) begin
      r_sram_addr <= w_sram_addr_next;
      r_dq_out    <= w_next_hi ? w_wdata_sel[31:16] : w_wdata_sel[15:0];
      r_dq_oe     <= w_op_wr;
      r_we_n      <= ~(w_op_wr && (w_cnt_next != LastCnt));
    end else begin
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_lo     <= '0;
      r_read_data <= '0;
    end else if (!r_is_wr && w_last) begin
      if (r_state == StLo) r_rd_lo <= sram_dq_in;
      if (r_state == StHi) r_read_data <= {sram_dq_in, r_rd_lo};
    end
  end

  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

endmodule
